ir_sequencer: RTL and testbench
===============================

IR_SEQUENCER -- requirements
Module: ir_sequencer

Interface
REQ-001 Parameter NT, default 8, meaning number of T-states per instruction; legal values are 4 to 8.
REQ-002 Port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 Port reset_n, input, 1, reset; asynchronous, active-low.
REQ-004 Port halt, input, 1, stop request, honoured only at an instruction boundary.
REQ-005 Port ucode_rt, input, 1, microcode end-of-instruction; return to T0 on the next edge.
REQ-006 Port ucode_iol, input, 1, microcode request to drive IR low byte onto bus.
REQ-007 Port ucode_ioh, input, 1, microcode request to drive IR high byte onto bus.
REQ-008 Port ucode_busy, input, 1, microcode has another bus driver enabled this cycle.
REQ-009 Port ir_value, input, 16, current IR contents.
REQ-010 Port tstate, output, 3, current T-state.
REQ-011 Port uaddr, output, 11, microcode address, equal to {ir_value[15:8], tstate}.
REQ-012 Ports pc_en, ar_load, mem_en, ir_load and pc_inc, output, 1 each, fetch controls.
REQ-013 Ports ir_enl and ir_enh, output, 1 each, IR bus-drive enables.
REQ-014 Port halted, output, 1, sequencer is stopped.
REQ-015 Port bus_conflict, output, 1, sticky error flag.

Function
REQ-016 The block SHALL implement two states, RUN and HALTED, plus a tstate counter with range 0 to NT-1.
REQ-017 In RUN, tstate SHALL increment by one each clk edge and SHALL wrap from NT-1 to 0.
REQ-018 In RUN with tstate at least 2, ucode_rt=1 SHALL load tstate=0 on the next edge.
REQ-019 ucode_rt SHALL be ignored at T0 and T1.
REQ-020 T0 SHALL assert pc_en=1 and ar_load=1, with all other controls 0.
REQ-021 T1 SHALL assert mem_en=1, ir_load=1 and pc_inc=1, with all other controls 0.
REQ-022 In T2 and later (execute), the fetch controls SHALL be 0.
REQ-023 In execute, ir_enl SHALL equal ucode_iol and ir_enh SHALL equal ucode_ioh, unless a conflict exists.
REQ-024 A conflict is (ucode_iol & ucode_ioh) | ((ucode_iol | ucode_ioh) & ucode_busy), evaluated in execute only.
REQ-025 On a conflict, ir_enl and ir_enh SHALL both be 0 in that same cycle (combinational).
REQ-026 On a conflict, bus_conflict SHALL be set at the next edge and SHALL remain 1 until reset.
REQ-027 ir_load and any of ir_enl or ir_enh SHALL never be 1 in the same cycle.
REQ-028 pc_en and mem_en SHALL never be 1 in the same cycle.
REQ-029 The instruction boundary is the edge on which tstate would load 0, either by wrap or by ucode_rt.
REQ-030 halt=1 at the boundary SHALL enter HALTED with tstate=0.
REQ-031 halt asserted mid-instruction SHALL NOT cut the instruction short.
REQ-032 HALTED SHALL hold tstate=0, drive all control outputs 0 and drive halted=1.
REQ-033 In HALTED, halt=0 sampled at an edge SHALL return the block to RUN, with T0 controls in the following cycle.
REQ-034 uaddr SHALL be combinational and valid in every state, including HALTED.
REQ-035 If ucode_rt and the wrap coincide, the result SHALL be the same tstate=0.

Reset
REQ-036 reset_n=0 SHALL immediately, without a clock, force state=RUN, tstate=0 and bus_conflict=0.
REQ-037 While reset_n=0, all control outputs SHALL be forced to 0 and halted SHALL be 0.
REQ-038 On the first clk edge after reset_n rises, tstate SHALL NOT advance.
REQ-039 In the first cycle after reset_n rises, the block SHALL present T0 controls; the first advance is on the second edge.
REQ-040 Reset asserted mid-instruction SHALL abort the instruction with no partial output pulse after assertion.

Verification
REQ-041 Scenario, reset release with NT=8 and no ucode_rt: tstate runs 0,1,...,7,0. pc_en/ar_load=1 only at T0; ir_load/pc_inc/mem_en=1 only at T1.
REQ-042 Scenario, ir_value=16'h9DD0 at T3: uaddr=11'h4EB. Then ucode_rt=1 at T3 gives tstate=0 on the next edge, and ucode_rt=1 at T1 is ignored (next tstate=2).
REQ-043 Scenario, ucode_iol=1 at T2 with ucode_ioh=0 and ucode_busy=0: ir_enl=1, ir_enh=0, bus_conflict=0.
REQ-044 Scenario, ucode_iol=1 and ucode_busy=1 at T4: ir_enl=0 in that cycle, bus_conflict=1 from the next edge, still 1 after 10 further cycles, cleared only by reset_n=0.
REQ-045 Scenario, halt=1 raised at T3: the instruction completes through T7, then halted=1 with all controls 0. halt=0 gives halted=0 after one edge and T0 controls next.
REQ-046 Scenario, reset_n=0 pulsed mid-T1 without a clock edge: ir_load drops to 0 immediately; after release tstate=0 and T0 controls are present.

Source files
------------

// File: rtl/ir_sequencer.sv
// rtl/ir_sequencer.sv - instruction T-state sequencer with fetch controls, IR bus enables and halt
module ir_sequencer #(
  parameter int NT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        halt,
  input  logic        ucode_rt,
  input  logic        ucode_iol,
  input  logic        ucode_ioh,
  input  logic        ucode_busy,
  input  logic [15:0] ir_value,
  output logic [2:0]  tstate,
  output logic [10:0] uaddr,
  output logic        pc_en,
  output logic        ar_load,
  output logic        mem_en,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        ir_enl,
  output logic        ir_enh,
  output logic        halted,
  output logic        bus_conflict
);

  typedef enum logic {RUN, HALTED} state_t;

  localparam logic [2:0] T_LAST = 3'(NT - 1);

  state_t     state, state_nxt;
  logic [2:0] t_nxt;
  logic       armed;
  logic       conflict;
  logic       execute;
  logic       boundary;
  logic       pc_en_r, ar_load_r, mem_en_r, ir_load_r, pc_inc_r;
  logic       ir_enl_r, ir_enh_r, halted_r;
  logic       unused_ir_low;

  assign unused_ir_low = ^ir_value[7:0];
  assign uaddr         = {ir_value[15:8], tstate};

  // armed stays low for the first edge after reset so T0 is presented for a full cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      tstate       <= 3'd0;
      armed        <= 1'b0;
      bus_conflict <= 1'b0;
    end else begin
      state        <= state_nxt;
      tstate       <= t_nxt;
      armed        <= 1'b1;
      bus_conflict <= bus_conflict | conflict;
    end
  end

  always_comb begin
    state_nxt = state;
    t_nxt     = tstate;
    conflict  = 1'b0;
    pc_en_r   = 1'b0;
    ar_load_r = 1'b0;
    mem_en_r  = 1'b0;
    ir_load_r = 1'b0;
    pc_inc_r  = 1'b0;
    ir_enl_r  = 1'b0;
    ir_enh_r  = 1'b0;
    halted_r  = 1'b0;
    execute   = (tstate >= 3'd2);
    boundary  = (tstate == T_LAST) || (execute && ucode_rt);

    case (state)
      RUN: begin
        if (tstate == 3'd0) begin
          pc_en_r   = 1'b1;
          ar_load_r = 1'b1;
        end else if (tstate == 3'd1) begin
          mem_en_r  = 1'b1;
          ir_load_r = 1'b1;
          pc_inc_r  = 1'b1;
        end else begin
          conflict = (ucode_iol & ucode_ioh) | ((ucode_iol | ucode_ioh) & ucode_busy);
          ir_enl_r = ucode_iol & ~conflict;
          ir_enh_r = ucode_ioh & ~conflict;
        end

        if (armed) begin
          if (boundary) begin
            t_nxt = 3'd0;
            if (halt) state_nxt = HALTED;
          end else begin
            t_nxt = tstate + 3'd1;
          end
        end
      end
      HALTED: begin
        halted_r = 1'b1;
        t_nxt    = 3'd0;
        if (!halt) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // reset forces every control low at once, even though tstate=0 would otherwise decode T0
  assign pc_en   = pc_en_r   & reset_n;
  assign ar_load = ar_load_r & reset_n;
  assign mem_en  = mem_en_r  & reset_n;
  assign ir_load = ir_load_r & reset_n;
  assign pc_inc  = pc_inc_r  & reset_n;
  assign ir_enl  = ir_enl_r  & reset_n;
  assign ir_enh  = ir_enh_r  & reset_n;
  assign halted  = halted_r  & reset_n;

endmodule

// File: tb/tb_ir_sequencer.sv
// tb/tb_ir_sequencer.sv - directed scoreboard bench for ir_sequencer
module tb_ir_sequencer;

  logic        clk;
  logic        reset_n;
  logic        halt;
  logic        ucode_rt;
  logic        ucode_iol;
  logic        ucode_ioh;
  logic        ucode_busy;
  logic [15:0] ir_value;
  logic [2:0]  tstate;
  logic [10:0] uaddr;
  logic        pc_en, ar_load, mem_en, ir_load, pc_inc;
  logic        ir_enl, ir_enh, halted, bus_conflict;
  logic [7:0]  ctrl;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [7:0] C_T0   = 8'hC0;
  localparam logic [7:0] C_T1   = 8'h38;
  localparam logic [7:0] C_NONE = 8'h00;
  localparam logic [7:0] C_ENL  = 8'h04;
  localparam logic [7:0] C_ENH  = 8'h02;
  localparam logic [7:0] C_HALT = 8'h01;

  ir_sequencer #(.NT(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .halt         (halt),
    .ucode_rt     (ucode_rt),
    .ucode_iol    (ucode_iol),
    .ucode_ioh    (ucode_ioh),
    .ucode_busy   (ucode_busy),
    .ir_value     (ir_value),
    .tstate       (tstate),
    .uaddr        (uaddr),
    .pc_en        (pc_en),
    .ar_load      (ar_load),
    .mem_en       (mem_en),
    .ir_load      (ir_load),
    .pc_inc       (pc_inc),
    .ir_enl       (ir_enl),
    .ir_enh       (ir_enh),
    .halted       (halted),
    .bus_conflict (bus_conflict)
  );

  assign ctrl = {pc_en, ar_load, mem_en, ir_load, pc_inc, ir_enl, ir_enh, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ctrl_of(input int t);
    if (t == 0) return C_T0;
    if (t == 1) return C_T1;
    return C_NONE;
  endfunction

  task automatic push(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: got %h required an expectation", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: got %h required %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk(input int t, input logic [7:0] c, input logic bc);
    push("tstate", 16'(t));
    push("ctrl", {8'h00, c});
    push("bus_conflict", {15'h0, bc});
    pop_cmp({13'h0, tstate});
    pop_cmp({8'h00, ctrl});
    pop_cmp({15'h0, bus_conflict});
  endtask

  task automatic chk_uaddr(input logic [10:0] v);
    push("uaddr", {5'h0, v});
    pop_cmp({5'h0, uaddr});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    halt       = 1'b0;
    ucode_rt   = 1'b0;
    ucode_iol  = 1'b0;
    ucode_ioh  = 1'b0;
    ucode_busy = 1'b0;
    ir_value   = 16'h0000;
    #2;
    chk(0, C_NONE, 1'b0);

    // release between edges, then one held edge before counting starts
    @(posedge clk);
    #2 reset_n = 1'b1;
    #1 chk(0, C_T0, 1'b0);
    tick();
    chk(0, C_T0, 1'b0);
    for (int t = 1; t <= 8; t++) begin
      tick();
      chk(t % 8, ctrl_of(t % 8), 1'b0);
    end

    tick(); tick(); tick();
    chk(3, C_NONE, 1'b0);
    ir_value = 16'h9DD0;
    #1 chk_uaddr(11'h4EB);
    ucode_rt = 1'b1;
    tick();
    chk(0, C_T0, 1'b0);
    ucode_rt = 1'b0;
    tick();
    chk(1, C_T1, 1'b0);
    ucode_rt = 1'b1;
    ucode_iol = 1'b1;
    #1 chk(1, C_T1, 1'b0);
    tick();
    ucode_rt = 1'b0;
    chk(2, C_ENL, 1'b0);
    ucode_iol = 1'b0;
    ucode_ioh = 1'b1;
    #1 chk(2, C_ENH, 1'b0);
    ucode_ioh = 1'b0;

    // bus conflict at T4 suppresses the enable now, flags on the next edge
    tick(); tick();
    ucode_iol  = 1'b1;
    ucode_busy = 1'b1;
    #1 chk(4, C_NONE, 1'b0);
    tick();
    ucode_iol  = 1'b0;
    ucode_busy = 1'b0;
    #1 chk(5, C_NONE, 1'b1);
    ucode_iol = 1'b1;
    ucode_ioh = 1'b1;
    #1 chk(5, C_NONE, 1'b1);
    ucode_iol = 1'b0;
    ucode_ioh = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk(7, C_NONE, 1'b1);
    reset_n = 1'b0;
    #1 chk(0, C_NONE, 1'b0);
    reset_n = 1'b1;
    #1 chk(0, C_T0, 1'b0);

    tick();
    chk(0, C_T0, 1'b0);
    tick(); tick(); tick();
    halt = 1'b1;
    #1 chk(3, C_NONE, 1'b0);
    for (int t = 4; t <= 7; t++) begin
      tick();
      chk(t, C_NONE, 1'b0);
    end
    tick();
    chk(0, C_HALT, 1'b0);
    chk_uaddr(11'h4E8);
    tick();
    chk(0, C_HALT, 1'b0);
    halt = 1'b0;
    tick();
    chk(0, C_T0, 1'b0);
    tick();
    chk(1, C_T1, 1'b0);

    // asynchronous reset pulse inside T1, no clock edge involved
    reset_n = 1'b0;
    #1 chk(0, C_NONE, 1'b0);
    reset_n = 1'b1;
    #1 chk(0, C_T0, 1'b0);
    tick();
    chk(0, C_T0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    chk(7, C_NONE, 1'b0);
    ucode_rt = 1'b1;
    tick();
    ucode_rt = 1'b0;
    chk(0, C_T0, 1'b0);
    tick();
    chk(1, C_T1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
